// File: rtl/tf530_arb.sv
// Bus arbiter between the 68030 accelerator and Amiga-side DMA masters.
// Hands the 68000-side bus to a DMA master via BR20/BG20, then BG/BGACK, with grant timeout.
module tf530_arb (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       CLK7M,
    input  logic       AS20,
    input  logic       AS,
    input  logic       BR,
    input  logic       BGACK,
    input  logic       BG20,
    output logic       BR20,
    output logic       BG,
    output logic       BGACK20,
    output logic       HALTBUS,
    output logic       TIMEOUT,
    output logic [2:0] ARB_STATE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAITBUS = 3'd2,
        GRANT   = 3'd3,
        OWNED   = 3'd4,
        RELEASE = 3'd5
    } state_t;

    state_t     state, state_nx;
    logic       br_p0, br_p1;
    logic       bgack_p0, bgack_p1;
    logic       c7_p0, c7_p1, c7_p2;
    logic       e7;
    logic [5:0] grant_cnt, grant_cnt_nx;
    logic [1:0] rel_cnt, rel_cnt_nx;
    logic       rel_done;
    logic       go_release;
    logic       br20_nx, bg_nx, bgack20_nx, halt_nx, timeout_nx;

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous 7M sample for edge detect
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            br_p0    <= 1'b1;
            br_p1    <= 1'b1;
            bgack_p0 <= 1'b1;
            bgack_p1 <= 1'b1;
            c7_p0    <= 1'b0;
            c7_p1    <= 1'b0;
            c7_p2    <= 1'b0;
        end else begin
            br_p0    <= BR;
            br_p1    <= br_p0;
            bgack_p0 <= BGACK;
            bgack_p1 <= bgack_p0;
            c7_p0    <= CLK7M;
            c7_p1    <= c7_p0;
            c7_p2    <= c7_p1;
        end
    end

    assign e7       = c7_p1 & ~c7_p2;
    assign rel_done = (rel_cnt == 2'd2) || ((rel_cnt == 2'd1) && e7);

    always_comb begin
        state_nx     = state;
        grant_cnt_nx = grant_cnt;
        rel_cnt_nx   = rel_cnt;
        br20_nx      = BR20;
        bg_nx        = BG;
        bgack20_nx   = BGACK20;
        halt_nx      = HALTBUS;
        timeout_nx   = 1'b0;
        go_release   = 1'b0;

        case (state)
            IDLE: begin
                if (!br_p1) begin
                    state_nx = REQ;
                    br20_nx  = 1'b0;
                end
            end
            REQ: begin
                if (!BG20) begin
                    state_nx = WAITBUS;
                end else if (br_p1) begin
                    go_release = 1'b1;
                end
            end
            WAITBUS: begin
                // Only hand the bus over on a 7M edge once both sides are idle
                if (e7 && AS20 && AS) begin
                    state_nx     = GRANT;
                    bg_nx        = 1'b0;
                    halt_nx      = 1'b1;
                    grant_cnt_nx = 6'd0;
                end
            end
            GRANT: begin
                if (!bgack_p1) begin
                    state_nx   = OWNED;
                    bg_nx      = 1'b1;
                    bgack20_nx = 1'b0;
                end else if (br_p1) begin
                    go_release = 1'b1;
                end else if (e7) begin
                    if (grant_cnt == 6'd63) begin
                        go_release = 1'b1;
                        timeout_nx = 1'b1;
                    end else begin
                        grant_cnt_nx = grant_cnt + 6'd1;
                    end
                end
            end
            OWNED: begin
                if (bgack_p1) begin
                    go_release = 1'b1;
                end
            end
            RELEASE: begin
                if (e7 && (rel_cnt != 2'd2)) begin
                    rel_cnt_nx = rel_cnt + 2'd1;
                end
                // Two 7M edges of turnaround before the accelerator drives the bus again
                if (rel_done && BG20) begin
                    state_nx = IDLE;
                    halt_nx  = 1'b0;
                end
            end
            default: begin
                state_nx   = IDLE;
                br20_nx    = 1'b1;
                bg_nx      = 1'b1;
                bgack20_nx = 1'b1;
                halt_nx    = 1'b0;
            end
        endcase

        if (go_release) begin
            state_nx   = RELEASE;
            br20_nx    = 1'b1;
            bg_nx      = 1'b1;
            bgack20_nx = 1'b1;
            halt_nx    = 1'b1;
            rel_cnt_nx = 2'd0;
        end
    end

    // Stage p3: FSM state, counters and registered bus outputs
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            grant_cnt <= 6'd0;
            rel_cnt   <= 2'd0;
            BR20      <= 1'b1;
            BG        <= 1'b1;
            BGACK20   <= 1'b1;
            HALTBUS   <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            state     <= state_nx;
            grant_cnt <= grant_cnt_nx;
            rel_cnt   <= rel_cnt_nx;
            BR20      <= br20_nx;
            BG        <= bg_nx;
            BGACK20   <= bgack20_nx;
            HALTBUS   <= halt_nx;
            TIMEOUT   <= timeout_nx;
        end
    end

    assign ARB_STATE = state;

endmodule

// File: tb/tb_tf530_arb.sv
// Randomised bench for tf530_arb against a cycle-level reference model of the arbitration rules.
module tb_tf530_arb;

    logic       CLKCPU = 1'b0;
    logic       RESET, CLK7M, AS20, AS, BR, BGACK, BG20;
    logic       BR20, BG, BGACK20, HALTBUS, TIMEOUT;
    logic [2:0] ARB_STATE;

    localparam int S_IDLE = 0, S_REQ = 1, S_WAITBUS = 2, S_GRANT = 3, S_OWNED = 4, S_RELEASE = 5;

    int total = 0;
    int bad   = 0;
    int to_seen;
    int c7_cnt, c7_half;

    int m_state, grant_e7, rel_e7;
    bit m_timeout;
    bit br_hist[$], bgack_hist[$], c7_hist[$];

    tf530_arb dut (
        .CLKCPU(CLKCPU), .RESET(RESET), .CLK7M(CLK7M), .AS20(AS20), .AS(AS),
        .BR(BR), .BGACK(BGACK), .BG20(BG20), .BR20(BR20), .BG(BG),
        .BGACK20(BGACK20), .HALTBUS(HALTBUS), .TIMEOUT(TIMEOUT), .ARB_STATE(ARB_STATE)
    );

    always #5 CLKCPU = ~CLKCPU;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = S_IDLE;
        grant_e7   = 0;
        rel_e7     = 0;
        m_timeout  = 1'b0;
        br_hist    = '{1'b1, 1'b1, 1'b1};
        bgack_hist = '{1'b1, 1'b1, 1'b1};
        c7_hist    = '{1'b0, 1'b0, 1'b0};
    endtask

    // One rising edge: the FSM sees pins as they were two edges ago
    task automatic model_step();
        bit br_s, bgack_s, e7;
        br_s    = br_hist[1];
        bgack_s = bgack_hist[1];
        e7      = c7_hist[1] && !c7_hist[2];
        m_timeout = 1'b0;
        case (m_state)
            S_IDLE:    if (!br_s) m_state = S_REQ;
            S_REQ: begin
                if (!BG20) m_state = S_WAITBUS;
                else if (br_s) begin m_state = S_RELEASE; rel_e7 = 0; end
            end
            S_WAITBUS: if (e7 && AS20 && AS) begin m_state = S_GRANT; grant_e7 = 0; end
            S_GRANT: begin
                if (!bgack_s) m_state = S_OWNED;
                else if (br_s) begin m_state = S_RELEASE; rel_e7 = 0; end
                else if (e7) begin
                    grant_e7++;
                    if (grant_e7 == 64) begin m_state = S_RELEASE; rel_e7 = 0; m_timeout = 1'b1; end
                end
            end
            S_OWNED:   if (bgack_s) begin m_state = S_RELEASE; rel_e7 = 0; end
            default: begin
                if (e7) rel_e7++;
                if (rel_e7 >= 2 && BG20) m_state = S_IDLE;
            end
        endcase
        br_hist    = {BR, br_hist[0:1]};
        bgack_hist = {BGACK, bgack_hist[0:1]};
        c7_hist    = {CLK7M, c7_hist[0:1]};
    endtask

    function automatic logic [7:0] model_out();
        logic [7:0] v;
        v[7:5] = m_state[2:0];
        v[4]   = !(m_state inside {S_REQ, S_WAITBUS, S_GRANT, S_OWNED});
        v[3]   = (m_state != S_GRANT);
        v[2]   = (m_state != S_OWNED);
        v[1]   = (m_state inside {S_GRANT, S_OWNED, S_RELEASE});
        v[0]   = m_timeout;
        return v;
    endfunction

    task automatic step();
        if (c7_cnt == 0) begin
            CLK7M  = ~CLK7M;
            c7_cnt = c7_half;
        end else begin
            c7_cnt--;
        end
        @(posedge CLKCPU);
        #1;
        model_step();
        chk("cycle", {ARB_STATE, BR20, BG, BGACK20, HALTBUS, TIMEOUT}, model_out());
        if (TIMEOUT === 1'b1) to_seen++;
    endtask

    task automatic wait_state(input int s, input int limit, input string tag);
        int n = 0;
        while (m_state != s && n < limit) begin
            step();
            n++;
        end
        chk(tag, ARB_STATE, s);
    endtask

    task automatic settle();
        BR = 1'b1; BGACK = 1'b1; BG20 = 1'b1; AS20 = 1'b1; AS = 1'b1;
        wait_state(S_IDLE, 200, "settle_idle");
        repeat (3) step();
    endtask

    task automatic get_grant(input bit deferred);
        BR = 1'b0;
        step();
        step();
        chk("br20_before", BR20, 1);
        step();
        chk("br20_latency", BR20, 0);
        BG20 = 1'b0; AS = 1'b1; AS20 = deferred ? 1'b0 : 1'b1;
        wait_state(S_WAITBUS, 5, "waitbus");
        if (deferred) begin
            repeat ($urandom_range(15, 30)) step();
            chk("defer_bg_held", BG, 1);
            AS20 = 1'b1;
        end
        wait_state(S_GRANT, 30, "grant");
        chk("grant_bg", BG, 0);
        chk("grant_halt", HALTBUS, 1);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) BR    = ~BR;
            if ($urandom_range(0, 7) == 0) BGACK = ~BGACK;
            if ($urandom_range(0, 5) == 0) BG20  = ~BG20;
            if ($urandom_range(0, 4) == 0) AS20  = ~AS20;
            if ($urandom_range(0, 6) == 0) AS    = ~AS;
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; CLK7M = 1'b0; AS20 = 1'b1; AS = 1'b1;
        BR = 1'b1; BGACK = 1'b1; BG20 = 1'b1;
        c7_half = 2; c7_cnt = 0; to_seen = 0;
        model_reset();
        #12;
        chk("rst_state", ARB_STATE, 0);
        chk("rst_br20", BR20, 1);
        chk("rst_bg", BG, 1);
        chk("rst_bgack20", BGACK20, 1);
        chk("rst_halt", HALTBUS, 0);
        chk("rst_timeout", TIMEOUT, 0);
        #10 RESET = 1'b1;
        repeat (4) step();

        // Basic grant and handover to the DMA master
        get_grant(1'b0);
        BGACK = 1'b0;
        step();
        step();
        chk("bgack20_before", BGACK20, 1);
        step();
        chk("bgack20_latency", BGACK20, 0);
        chk("owned_bg", BG, 1);
        BR = 1'b1;
        repeat ($urandom_range(5, 20)) step();
        chk("owned_ignores_br", ARB_STATE, S_OWNED);
        BGACK = 1'b1;
        wait_state(S_RELEASE, 5, "owned_release");
        settle();

        // Deferred grant while the 68030 holds its strobe
        c7_half = $urandom_range(2, 4);
        get_grant(1'b1);
        settle();

        // Grant timeout with BGACK never answering
        get_grant(1'b0);
        to_seen = 0;
        wait_state(S_RELEASE, 800, "timeout_release");
        chk("timeout_pulses", to_seen, 1);
        BG20 = 1'b1;
        wait_state(S_IDLE, 40, "timeout_idle");
        step();
        chk("rereq_after_release", ARB_STATE, S_REQ);
        settle();

        // Request withdrawn during grant
        get_grant(1'b0);
        to_seen = 0;
        repeat ($urandom_range(0, 10)) step();
        BR = 1'b1;
        wait_state(S_RELEASE, 5, "withdraw_release");
        chk("withdraw_no_timeout", to_seen, 0);
        settle();

        // BGACK low and BR high seen in the same cycle
        get_grant(1'b0);
        BGACK = 1'b0; BR = 1'b1;
        repeat (3) step();
        chk("simul_owned", ARB_STATE, S_OWNED);
        settle();

        rand_cycles(400);
        settle();

        // Asynchronous reset while the DMA master owns the bus
        c7_half = $urandom_range(2, 4);
        get_grant(1'b0);
        BGACK = 1'b0;
        wait_state(S_OWNED, 5, "pre_reset_owned");
        repeat (3) step();
        #2 RESET = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_bgack20", BGACK20, 1);
        chk("mid_rst_br20", BR20, 1);
        chk("mid_rst_halt", HALTBUS, 0);
        chk("mid_rst_state", ARB_STATE, 0);
        BGACK = 1'b1;
        repeat (3) begin
            @(posedge CLKCPU);
            #1;
            chk("rst_hold_state", ARB_STATE, 0);
        end
        #2 RESET = 1'b1;
        step();
        step();
        chk("rst_rel_edge2", ARB_STATE, S_IDLE);
        step();
        chk("rst_rel_edge3", ARB_STATE, S_REQ);
        settle();

        rand_cycles(400);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
